word_serializer: RTL and testbench

Splits IN_WIDTH-bit words into OUT_WIDTH-bit chunks, least-significant chunk first, advancing one chunk per `step` pulse. Sits between byte-level logic and a narrow line interface: `step` comes from a `clock_divider` (e.g. PULSE_PERIOD=4 for 2-bit dibits), and output chunks feed the line driver. A one-word holding buffer lets back-to-back words serialize with no gap between them.

---
 rtl/word_serializer.sv | 97 +++++++++
 tb/tb_word_serializer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/word_serializer.sv
// Word-to-chunk serializer: emits IN_WIDTH-bit words as OUT_WIDTH-bit chunks, LS chunk first,
// one chunk per step pulse, with a one-word holding buffer for gap-free back-to-back words.
module word_serializer #(
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_last,
    output logic                 in_ready,
    input  logic                 step,
    output logic                 out_valid,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_last,
    output logic                 done
);

    localparam int N_CHUNKS = IN_WIDTH / OUT_WIDTH;
    localparam int IDX_W    = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHUNKS - 1);

    logic [IN_WIDTH-1:0] sh_data;
    logic                sh_last;
    logic                sh_valid;
    logic [IDX_W-1:0]    idx;

    logic [IN_WIDTH-1:0] buf_data;
    logic                buf_last;
    logic                buf_full;

    logic accept;
    logic advance;
    logic finishing;
    logic shifter_free;

    assign in_ready     = !buf_full && !rst;
    assign accept       = in_valid && in_ready;
    assign advance      = sh_valid && step;
    assign finishing    = advance && (idx == LAST_IDX);
    assign shifter_free = !sh_valid || finishing;

    assign out_valid = sh_valid;
    assign out_data  = sh_data[OUT_WIDTH-1:0];
    assign out_last  = sh_valid && sh_last && (idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_data  <= '0;
            sh_last  <= 1'b0;
            sh_valid <= 1'b0;
            idx      <= '0;
            buf_data <= '0;
            buf_last <= 1'b0;
            buf_full <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= out_last && step;

            if (shifter_free && buf_full) begin
                // Refill from the buffer; a same-cycle accept keeps the buffer occupied.
                sh_data  <= buf_data;
                sh_last  <= buf_last;
                sh_valid <= 1'b1;
                idx      <= '0;
                if (accept) begin
                    buf_data <= in_data;
                    buf_last <= in_last;
                end else begin
                    buf_full <= 1'b0;
                end
            end else if (shifter_free && accept) begin
                sh_data  <= in_data;
                sh_last  <= in_last;
                sh_valid <= 1'b1;
                idx      <= '0;
            end else begin
                if (finishing) begin
                    sh_data  <= '0;
                    sh_last  <= 1'b0;
                    sh_valid <= 1'b0;
                    idx      <= '0;
                end else if (advance) begin
                    sh_data <= sh_data >> OUT_WIDTH;
                    idx     <= idx + IDX_W'(1);
                end
                if (accept) begin
                    buf_data <= in_data;
                    buf_last <= in_last;
                    buf_full <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_word_serializer.sv
// Self-checking bench for word_serializer (IN=8, OUT=2): scoreboard of expected chunks is
// filled at each accepted word and drained by a monitor on every counted step.
`timescale 1ns/1ps
module tb_word_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;
    logic       step;
    logic       out_valid;
    logic [1:0] out_data;
    logic       out_last;
    logic       done;

    int n_cmp = 0;
    int n_err = 0;

    logic [2:0] sb[$];          // {last, chunk}
    logic       mon_en   = 1'b0;
    logic       exp_done = 1'b0;
    logic       step_en  = 1'b0;
    logic       step_man = 1'b0;

    word_serializer #(.IN_WIDTH(8), .OUT_WIDTH(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .step(step),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .done(done)
    );

    always #5 clk = ~clk;

    // Step source: every 4th cycle when enabled, plus manual pulses.
    initial begin
        int cnt;
        cnt  = 0;
        step = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            step = (step_en && cnt == 3) || step_man;
            cnt  = step_en ? (cnt + 1) % 4 : 0;
        end
    end

    // Scoreboard monitor: compare each consumed chunk and the done pulse that must follow.
    always @(negedge clk) begin
        if (mon_en) begin
            n_cmp++;
            if (done !== exp_done) begin
                n_err++;
                $display("FAIL done_pulse: got %b expected %b at %0t", done, exp_done, $time);
            end
            exp_done = 1'b0;
            if (step === 1'b1 && out_valid === 1'b1) begin
                logic [2:0] e;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_chunk: got data %b last %b expected none", out_data, out_last);
                end else begin
                    e = sb.pop_front();
                    if ({out_last, out_data} !== e) begin
                        n_err++;
                        $display("FAIL chunk: got last %b data %b expected last %b data %b at %0t",
                                 out_last, out_data, e[2], e[1:0], $time);
                    end
                    exp_done = e[2] && !rst;
                end
            end
        end
    end

    task automatic push_word(input logic [7:0] d, input logic l);
        for (int i = 0; i < 4; i++)
            sb.push_back({l && (i == 3), d[2*i +: 2]});
    endtask

    // Entered and left at posedge+1.
    task automatic send(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        forever begin
            @(negedge clk);
            if (in_ready === 1'b1) break;
            n++;
            if (n > 200) begin
                n_cmp++;
                n_err++;
                $display("FAIL send_timeout: in_ready %b expected 1", in_ready);
                break;
            end
        end
        @(posedge clk);
        push_word(d, l);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic man_step();
        step_man = 1'b1;
        @(posedge clk); #1;
        step_man = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(output int dones, output int gaps);
        int n;
        n = 0;
        dones = 0;
        gaps = 0;
        while (!(sb.size() == 0 && out_valid === 1'b0)) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
            if (out_valid !== 1'b1 && sb.size() != 0) gaps++;
            n++;
            if (n > 500) begin
                n_cmp++;
                n_err++;
                $display("FAIL idle_timeout: %0d chunks pending, expected 0", sb.size());
                break;
            end
        end
        repeat (3) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 8'hAA;
        in_last = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if ({in_ready, out_valid, done, out_last, out_data} !== 5'b0) begin
                n_err++;
                $display("FAIL reset_outputs: got rdy %b vld %b done %b last %b data %b expected all 0",
                         in_ready, out_valid, done, out_last, out_data);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: got rdy %b vld %b expected rdy 1 vld 0", in_ready, out_valid);
        end
        mon_en = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        int dones, gaps;
        step_en = 1'b1;
        send(8'hB4, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 2'b00) begin
            n_err++;
            $display("FAIL single_latency: got vld %b data %b expected vld 1 data 00", out_valid, out_data);
        end
        wait_idle(dones, gaps);
        n_cmp++;
        if (dones !== 1) begin
            n_err++;
            $display("FAIL single_done_count: got %0d expected 1", dones);
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_drain: got out_valid %b expected 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int dones, gaps;
        step_en = 1'b1;
        send(8'h1B, 1'b0);
        send(8'hE4, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_buffer_full: got in_ready %b expected 0", in_ready);
        end
        wait_idle(dones, gaps);
        n_cmp++;
        if (gaps !== 0) begin
            n_err++;
            $display("FAIL b2b_gap: got %0d gap cycles expected 0", gaps);
        end
        n_cmp++;
        if (dones !== 1 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_end: got dones %0d rdy %b expected dones 1 rdy 1", dones, in_ready);
        end
    endtask

    task automatic test_step_idle();
        int dones, gaps;
        step_en = 1'b0;
        repeat (5) man_step();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL idle_step_valid: got out_valid %b expected 0", out_valid);
        end
        step_en = 1'b1;
        send(8'h55, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 2'b01) begin
            n_err++;
            $display("FAIL idle_first_chunk: got vld %b data %b expected vld 1 data 01", out_valid, out_data);
        end
        wait_idle(dones, gaps);
        n_cmp++;
        if (dones !== 1 || gaps !== 0) begin
            n_err++;
            $display("FAIL idle_complete: got dones %0d gaps %0d expected 1 and 0", dones, gaps);
        end
    endtask

    task automatic test_simul_empty();
        int dones, gaps;
        step_en = 1'b0;
        send(8'hFF, 1'b0);
        repeat (3) man_step();
        in_valid = 1'b1;
        in_data  = 8'h00;
        in_last  = 1'b1;
        step_man = 1'b1;
        @(posedge clk);
        push_word(8'h00, 1'b1);
        #1;
        in_valid = 1'b0;
        step_man = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 2'b00 || out_last !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL simul_load: got vld %b data %b last %b rdy %b expected 1 00 0 1",
                     out_valid, out_data, out_last, in_ready);
        end
        step_en = 1'b1;
        wait_idle(dones, gaps);
        n_cmp++;
        if (dones !== 1 || gaps !== 0) begin
            n_err++;
            $display("FAIL simul_complete: got dones %0d gaps %0d expected 1 and 0", dones, gaps);
        end
    endtask

    task automatic test_reset_mid();
        int dones, gaps;
        step_en = 1'b0;
        send(8'hB4, 1'b1);
        send(8'h1B, 1'b0);
        repeat (2) man_step();
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL mid_rst_ready: got in_ready %b expected 0", in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({out_valid, out_data, out_last, done} !== 5'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL mid_rst_state: got vld %b data %b last %b done %b rdy %b expected 0 00 0 0 1",
                     out_valid, out_data, out_last, done, in_ready);
        end
        repeat (4) @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL mid_rst_discard: got out_valid %b expected 0", out_valid);
        end
        @(posedge clk); #1;
        step_en = 1'b1;
        send(8'h0F, 1'b1);
        wait_idle(dones, gaps);
        n_cmp++;
        if (dones !== 1 || gaps !== 0) begin
            n_err++;
            $display("FAIL mid_rst_next_word: got dones %0d gaps %0d expected 1 and 0", dones, gaps);
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        in_last = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_step_idle();
        test_simul_empty();
        test_reset_mid();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL leftover_chunks: got %0d expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
